// File: rtl/bf_pkg.sv
// Shared definitions for the beamformer weight commit controller.
//   NUM_CH          : number of beamformer channels
//   W_W             : width of each weight term
//   CH_W            : width of a channel index
//   BF_TICK_TIMEOUT : default ARMED wait before a forced apply
//   bf_wt_t         : one channel's weight set {cos1, sin1, cos2, sin2}
//   bf_commit_state_t : commit FSM states
package bf_pkg;

  localparam int NUM_CH          = 8;
  localparam int W_W             = 5;
  localparam int CH_W            = 3;
  localparam int BF_TICK_TIMEOUT = 16;

  typedef struct packed {
    logic [W_W-1:0] cos1;
    logic [W_W-1:0] sin1;
    logic [W_W-1:0] cos2;
    logic [W_W-1:0] sin2;
  } bf_wt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    APPLY = 2'd2
  } bf_commit_state_t;

endpackage

// File: rtl/bf_tick_timer.sv
// Cycle counter bounding how long the commit FSM waits for a frame tick.
// Ports:
//   CLOCK   in  system clock
//   RESET   in  synchronous active-high reset
//   enable  in  count while high (FSM is ARMED)
//   clear   in  return the count to zero (FSM not ARMED); wins over enable
//   timeout out high while enabled and the count equals TICK_TIMEOUT-1
module bf_tick_timer #(
  parameter int TICK_TIMEOUT = 16
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic enable,
  input  logic clear,
  output logic timeout
);

  localparam int              CNT_W = (TICK_TIMEOUT > 2) ? $clog2(TICK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_r;

  // Wait counter: zero outside ARMED, one step per ARMED cycle.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (enable) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // The FSM leaves ARMED on this pulse, so the counter never wraps in use.
  assign timeout = enable && (cnt_r == LAST);

endmodule

// File: rtl/bf_weight_commit_ctrl.sv
// Shadow/active weight bank controller for the phase-shift array.
// Writes land in a shadow bank; a commit copies all dirty channels into the
// active bank on one clock edge, aligned to a frame tick (or forced after a
// timeout), so downstream phase shifters never see a half-updated set.
// Ports:
//   CLOCK, RESET               clock, synchronous active-high reset
//   frame_tick                 safe-update pulse (used only while ARMED)
//   wr_valid/wr_ready          write handshake (ready only in IDLE)
//   wr_chan, wr_cos1..wr_sin2  write channel and weight terms
//   commit_req/commit_ack      commit request pulse / completion pulse
//   err_clr                    clears tick_err
//   w_cos_1..w_sin_2           active weights, NUM_CH x W_W each
//   dirty                      per-channel shadow-modified flags
//   busy                       FSM not IDLE
//   tick_err                   sticky: a commit was forced by timeout
module bf_weight_commit_ctrl
  import bf_pkg::*;
#(
  parameter int TICK_TIMEOUT = BF_TICK_TIMEOUT
) (
  input  logic                        CLOCK,
  input  logic                        RESET,
  input  logic                        frame_tick,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [CH_W-1:0]             wr_chan,
  input  logic [W_W-1:0]              wr_cos1,
  input  logic [W_W-1:0]              wr_sin1,
  input  logic [W_W-1:0]              wr_cos2,
  input  logic [W_W-1:0]              wr_sin2,
  input  logic                        commit_req,
  output logic                        commit_ack,
  input  logic                        err_clr,
  output logic [NUM_CH-1:0][W_W-1:0]  w_cos_1,
  output logic [NUM_CH-1:0][W_W-1:0]  w_sin_1,
  output logic [NUM_CH-1:0][W_W-1:0]  w_cos_2,
  output logic [NUM_CH-1:0][W_W-1:0]  w_sin_2,
  output logic [NUM_CH-1:0]           dirty,
  output logic                        busy,
  output logic                        tick_err
);

  bf_commit_state_t         state_r, state_nxt_s;
  bf_wt_t [NUM_CH-1:0]      shadow_r;
  bf_wt_t [NUM_CH-1:0]      active_r;
  logic   [NUM_CH-1:0]      dirty_r;
  logic   [NUM_CH-1:0]      wr_hit_s;
  logic   [NUM_CH-1:0]      dirty_merge_s;
  logic                     commit_ack_r;
  logic                     tick_err_r;
  logic                     wr_fire_s;
  logic                     timeout_s;
  logic                     noop_ack_s;
  logic                     force_s;
  logic                     apply_s;
  bf_wt_t                   wr_wt_s;

  assign wr_ready  = (state_r == IDLE) && !RESET;
  assign busy      = (state_r != IDLE);
  assign wr_fire_s = wr_valid && wr_ready;
  assign wr_wt_s   = '{cos1: wr_cos1, sin1: wr_sin1, cos2: wr_cos2, sin2: wr_sin2};

  // Timer runs only in ARMED and is zeroed everywhere else.
  bf_tick_timer #(
    .TICK_TIMEOUT (TICK_TIMEOUT)
  ) u_tick_timer (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .enable  (state_r == ARMED),
    .clear   (state_r != ARMED),
    .timeout (timeout_s)
  );

  // One-hot of the channel an accepted write targets; out-of-range channels match nothing.
  always_comb begin
    wr_hit_s = {NUM_CH{1'b0}};
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (wr_fire_s && (wr_chan == CH_W'(ch))) begin
        wr_hit_s[ch] = 1'b1;
      end else begin
        wr_hit_s[ch] = 1'b0;
      end
    end
  end

  // A same-cycle write belongs to the commit, so the commit decision sees the merged mask.
  assign dirty_merge_s = dirty_r | wr_hit_s;

  // Commit FSM next-state and per-cycle actions.
  always_comb begin
    state_nxt_s = state_r;
    noop_ack_s  = 1'b0;
    force_s     = 1'b0;
    apply_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (commit_req) begin
          if (dirty_merge_s == {NUM_CH{1'b0}}) begin
            noop_ack_s = 1'b1;
          end else begin
            state_nxt_s = ARMED;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ARMED: begin
        // A real tick in the timeout cycle is not a forced apply.
        if (frame_tick) begin
          state_nxt_s = APPLY;
        end else if (timeout_s) begin
          state_nxt_s = APPLY;
          force_s     = 1'b1;
        end else begin
          state_nxt_s = ARMED;
        end
      end
      APPLY: begin
        apply_s     = 1'b1;
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, completion pulse and sticky timeout flag.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_r      <= IDLE;
      commit_ack_r <= 1'b0;
      tick_err_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      commit_ack_r <= noop_ack_s | apply_s;
      if (force_s) begin
        tick_err_r <= 1'b1;
      end else if (err_clr) begin
        tick_err_r <= 1'b0;
      end else begin
        tick_err_r <= tick_err_r;
      end
    end
  end

  // Shadow bank: last accepted write per channel.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      shadow_r <= {NUM_CH{bf_wt_t'({4*W_W{1'b0}})}};
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (wr_hit_s[ch]) begin
          shadow_r[ch] <= wr_wt_s;
        end else begin
          shadow_r[ch] <= shadow_r[ch];
        end
      end
    end
  end

  // Active bank and dirty flags: all dirty channels move together on the APPLY edge.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      active_r <= {NUM_CH{bf_wt_t'({4*W_W{1'b0}})}};
      dirty_r  <= {NUM_CH{1'b0}};
    end else if (apply_s) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (dirty_r[ch]) begin
          active_r[ch] <= shadow_r[ch];
        end else begin
          active_r[ch] <= active_r[ch];
        end
      end
      dirty_r <= {NUM_CH{1'b0}};
    end else begin
      active_r <= active_r;
      dirty_r  <= dirty_merge_s;
    end
  end

  // Unpack the active bank onto the per-term output buses.
  always_comb begin
    w_cos_1 = {NUM_CH*W_W{1'b0}};
    w_sin_1 = {NUM_CH*W_W{1'b0}};
    w_cos_2 = {NUM_CH*W_W{1'b0}};
    w_sin_2 = {NUM_CH*W_W{1'b0}};
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_cos_1[ch] = active_r[ch].cos1;
      w_sin_1[ch] = active_r[ch].sin1;
      w_cos_2[ch] = active_r[ch].cos2;
      w_sin_2[ch] = active_r[ch].sin2;
    end
  end

  assign dirty      = dirty_r;
  assign commit_ack = commit_ack_r;
  assign tick_err   = tick_err_r;

endmodule

// File: tb/tb_bf_weight_commit_ctrl.sv
// Self-checking bench for bf_weight_commit_ctrl. A small bank model predicts
// the active weights each commit should produce; predictions are queued when
// the commit is issued and popped when commit_ack appears.
module tb_bf_weight_commit_ctrl;
  import bf_pkg::*;

  localparam int BW = NUM_CH * W_W;
  typedef struct packed {
    logic [BW-1:0] c1;
    logic [BW-1:0] s1;
    logic [BW-1:0] c2;
    logic [BW-1:0] s2;
  } bank_t;

  logic                       CLOCK = 1'b0;
  logic                       RESET, frame_tick, wr_valid, wr_ready;
  logic                       commit_req, commit_ack, err_clr, busy, tick_err;
  logic [CH_W-1:0]            wr_chan;
  logic [W_W-1:0]             wr_cos1, wr_sin1, wr_cos2, wr_sin2;
  logic [NUM_CH-1:0][W_W-1:0] w_cos_1, w_sin_1, w_cos_2, w_sin_2;
  logic [NUM_CH-1:0]          dirty;

  int n_checks = 0;
  int n_fail   = 0;

  bank_t             m_shadow, m_active, m_prev;
  logic [NUM_CH-1:0] m_dirty;
  bank_t             exp_q[$];

  always #5 CLOCK = ~CLOCK;

  bf_weight_commit_ctrl dut (
    .CLOCK(CLOCK), .RESET(RESET), .frame_tick(frame_tick),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_chan(wr_chan),
    .wr_cos1(wr_cos1), .wr_sin1(wr_sin1), .wr_cos2(wr_cos2), .wr_sin2(wr_sin2),
    .commit_req(commit_req), .commit_ack(commit_ack), .err_clr(err_clr),
    .w_cos_1(w_cos_1), .w_sin_1(w_sin_1), .w_cos_2(w_cos_2), .w_sin_2(w_sin_2),
    .dirty(dirty), .busy(busy), .tick_err(tick_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  // Drive one write (caller advances the clock) and record it in the model.
  task automatic set_write(input int ch, input logic [W_W-1:0] a, input logic [W_W-1:0] b,
                           input logic [W_W-1:0] c, input logic [W_W-1:0] d);
    wr_valid = 1'b1;
    wr_chan  = CH_W'(ch);
    wr_cos1  = a; wr_sin1 = b; wr_cos2 = c; wr_sin2 = d;
    m_shadow.c1[ch*W_W +: W_W] = a;
    m_shadow.s1[ch*W_W +: W_W] = b;
    m_shadow.c2[ch*W_W +: W_W] = c;
    m_shadow.s2[ch*W_W +: W_W] = d;
    m_dirty[ch] = 1'b1;
  endtask

  // Predict the active bank after the commit being issued and queue it.
  task automatic model_commit();
    m_prev = m_active;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (m_dirty[ch]) begin
        m_active.c1[ch*W_W +: W_W] = m_shadow.c1[ch*W_W +: W_W];
        m_active.s1[ch*W_W +: W_W] = m_shadow.s1[ch*W_W +: W_W];
        m_active.c2[ch*W_W +: W_W] = m_shadow.c2[ch*W_W +: W_W];
        m_active.s2[ch*W_W +: W_W] = m_shadow.s2[ch*W_W +: W_W];
      end
    end
    exp_q.push_back(m_active);
    m_dirty = {NUM_CH{1'b0}};
  endtask

  // Clock until commit_ack (bounded), checking latency, hold of old weights, then the popped prediction.
  task automatic expect_ack(input string tag, input int lat);
    int    n;
    bit    got;
    bank_t e;
    n   = 0;
    got = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step();
      frame_tick = 1'b0;
      commit_req = 1'b0;
      if (commit_ack === 1'b1) begin
        n   = i;
        got = 1'b1;
        break;
      end
      check_eq({tag, "_hold"}, 64'(w_cos_1), 64'(m_prev.c1));
    end
    if (!got) begin
      check_eq({tag, "_ack_seen"}, 64'(0), 64'(1));
    end else begin
      check_eq({tag, "_lat"}, 64'(n), 64'(lat));
      if (exp_q.size() == 0) begin
        check_eq({tag, "_unexpected_ack"}, 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check_eq({tag, "_cos1"}, 64'(w_cos_1), 64'(e.c1));
        check_eq({tag, "_sin1"}, 64'(w_sin_1), 64'(e.s1));
        check_eq({tag, "_cos2"}, 64'(w_cos_2), 64'(e.c2));
        check_eq({tag, "_sin2"}, 64'(w_sin_2), 64'(e.s2));
        check_eq({tag, "_dirty"}, 64'(dirty), 64'(0));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; frame_tick = 1'b0; wr_valid = 1'b0; commit_req = 1'b0; err_clr = 1'b0;
    wr_chan = 3'd0; wr_cos1 = 5'd0; wr_sin1 = 5'd0; wr_cos2 = 5'd0; wr_sin2 = 5'd0;
    m_shadow = '0; m_active = '0; m_prev = '0; m_dirty = '0;

    // Reset state
    step(); step();
    check_eq("rst_wr_ready_in_reset", 64'(wr_ready), 64'(0));
    RESET = 1'b0;
    step();
    check_eq("rst_cos1", 64'(w_cos_1), 64'(0));
    check_eq("rst_sin2", 64'(w_sin_2), 64'(0));
    check_eq("rst_dirty", 64'(dirty), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_ack", 64'(commit_ack), 64'(0));
    check_eq("rst_err", 64'(tick_err), 64'(0));
    check_eq("rst_wr_ready", 64'(wr_ready), 64'(1));

    // Write ch3, commit, tick three cycles into ARMED
    set_write(3, 5'd7, 5'd1, 5'd31, 5'd0);
    step(); wr_valid = 1'b0;
    check_eq("t2_dirty", 64'(dirty), 64'(8'h08));
    check_eq("t2_not_active_yet", 64'(w_cos_1), 64'(0));
    model_commit();
    commit_req = 1'b1;
    step(); commit_req = 1'b0;
    check_eq("t2_busy", 64'(busy), 64'(1));
    check_eq("t2_wr_ready_armed", 64'(wr_ready), 64'(0));
    step(); step();
    frame_tick = 1'b1;
    expect_ack("t2", 2);
    check_eq("t2_ch3_cos1", 64'(w_cos_1[3]), 64'(7));
    check_eq("t2_ch3_cos2", 64'(w_cos_2[3]), 64'(31));
    check_eq("t2_err", 64'(tick_err), 64'(0));
    step();
    check_eq("t2_ack_one_cycle", 64'(commit_ack), 64'(0));
    check_eq("t2_idle", 64'(busy), 64'(0));

    // Overwrite ch0 twice before commit
    set_write(0, 5'd1, 5'd1, 5'd1, 5'd1);
    step();
    set_write(0, 5'd2, 5'd2, 5'd2, 5'd2);
    step(); wr_valid = 1'b0;
    model_commit();
    commit_req = 1'b1;
    step(); commit_req = 1'b0;
    frame_tick = 1'b1;
    expect_ack("t3", 2);
    check_eq("t3_ch0", 64'(w_cos_1[0]), 64'(2));

    // Write in the same cycle as commit_req joins that commit
    set_write(1, 5'd9, 5'd10, 5'd11, 5'd12);
    model_commit();
    commit_req = 1'b1;
    step(); commit_req = 1'b0; wr_valid = 1'b0;
    check_eq("t3b_busy", 64'(busy), 64'(1));
    frame_tick = 1'b1;
    expect_ack("t3b", 2);

    // No-op commit with nothing dirty
    check_eq("t4_dirty0", 64'(dirty), 64'(0));
    model_commit();
    commit_req = 1'b1;
    expect_ack("t4", 1);
    check_eq("t4_busy", 64'(busy), 64'(0));

    // frame_tick in IDLE does nothing
    frame_tick = 1'b1;
    step(); frame_tick = 1'b0;
    check_eq("idle_tick_busy", 64'(busy), 64'(0));
    check_eq("idle_tick_ack", 64'(commit_ack), 64'(0));

    // Forced apply after timeout, sticky tick_err
    set_write(5, 5'd21, 5'd22, 5'd23, 5'd24);
    step(); wr_valid = 1'b0;
    model_commit();
    commit_req = 1'b1;
    expect_ack("t5", 18);
    check_eq("t5_err", 64'(tick_err), 64'(1));
    step(); step(); step();
    check_eq("t5_err_sticky", 64'(tick_err), 64'(1));
    err_clr = 1'b1;
    step(); err_clr = 1'b0;
    check_eq("t5_err_clr", 64'(tick_err), 64'(0));

    // err_clr in the timeout cycle loses to the timeout
    set_write(6, 5'd3, 5'd4, 5'd5, 5'd6);
    step(); wr_valid = 1'b0;
    model_commit();
    commit_req = 1'b1;
    step(); commit_req = 1'b0;
    repeat (15) step();
    check_eq("t5b_err_before", 64'(tick_err), 64'(0));
    check_eq("t5b_still_armed", 64'(busy), 64'(1));
    err_clr = 1'b1;
    step(); err_clr = 1'b0;
    check_eq("t5b_err_wins", 64'(tick_err), 64'(1));
    expect_ack("t5b", 1);
    err_clr = 1'b1;
    step(); err_clr = 1'b0;

    // Write held through ARMED is stalled, then taken in the first IDLE cycle
    set_write(4, 5'd10, 5'd11, 5'd12, 5'd13);
    step(); wr_valid = 1'b0;
    model_commit();
    commit_req = 1'b1;
    step(); commit_req = 1'b0;
    wr_valid = 1'b1; wr_chan = 3'd4;
    wr_cos1 = 5'd30; wr_sin1 = 5'd29; wr_cos2 = 5'd28; wr_sin2 = 5'd27;
    step();
    check_eq("t6_wr_ready_armed", 64'(wr_ready), 64'(0));
    check_eq("t6_dirty_armed", 64'(dirty), 64'(8'h10));
    frame_tick = 1'b1;
    expect_ack("t6", 2);
    check_eq("t6_wr_ready_idle", 64'(wr_ready), 64'(1));
    set_write(4, 5'd30, 5'd29, 5'd28, 5'd27);
    step(); wr_valid = 1'b0;
    check_eq("t6_dirty_after", 64'(dirty), 64'(m_dirty));
    model_commit();
    commit_req = 1'b1;
    step(); commit_req = 1'b0;
    frame_tick = 1'b1;
    expect_ack("t6b", 2);

    // Reset while ARMED abandons the commit
    set_write(2, 5'd17, 5'd18, 5'd19, 5'd20);
    step(); wr_valid = 1'b0;
    commit_req = 1'b1;
    step(); commit_req = 1'b0;
    check_eq("t7_armed", 64'(busy), 64'(1));
    RESET = 1'b1;
    step();
    check_eq("t7_wr_ready_in_reset", 64'(wr_ready), 64'(0));
    RESET = 1'b0;
    m_shadow = '0; m_active = '0; m_dirty = '0;
    exp_q.delete();
    frame_tick = 1'b1;
    step(); frame_tick = 1'b0;
    check_eq("t7_ack", 64'(commit_ack), 64'(0));
    check_eq("t7_busy", 64'(busy), 64'(0));
    check_eq("t7_dirty", 64'(dirty), 64'(0));
    step();
    check_eq("t7_ack_late", 64'(commit_ack), 64'(0));
    check_eq("t7_cos1", 64'(w_cos_1), 64'(m_active.c1));
    check_eq("t7_sin1", 64'(w_sin_1), 64'(m_active.s1));
    check_eq("t7_cos2", 64'(w_cos_2), 64'(m_active.c2));
    check_eq("t7_sin2", 64'(w_sin_2), 64'(m_active.s2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bf_weight_commit_ctrl.md
Name: bf_weight_commit_ctrl

Overview:
- Shadow/active weight-bank controller for the 8-channel phase-shift array.
- Accepts per-channel weight writes into a shadow bank, from the SPI decode or from a host sequencer.
- On commit, copies all dirty channels into the active bank in one atomic CLOCK edge, aligned to a phase-shift frame tick. The PHASESHIFT instances therefore never sample a half-updated weight set.
- Sits between the SPI block and the PHASESHIFT array in the top level, in the CLOCK domain.

Parameters:
- NUM_CH, 8, number of beamformer channels.
- W_W, 5, width of each weight term (cos1, sin1, cos2, sin2).
- TICK_TIMEOUT, 16, CLOCK cycles to wait in ARMED for frame_tick before a forced apply.

Ports:
- CLOCK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per ps_clock period (every 8 CLOCKs), marking a safe update point.
- wr_valid  in  1  weight write request.
- wr_ready  out  1  write accepted when wr_valid & wr_ready.
- wr_chan  in  3  target channel, 0..NUM_CH-1.
- wr_cos1, wr_sin1, wr_cos2, wr_sin2  in  W_W each  weight terms.
- commit_req  in  1  one-cycle pulse requesting shadow-to-active transfer.
- commit_ack  out  1  one-cycle pulse, high in the cycle the new active weights first appear.
- err_clr  in  1  clears tick_err.
- w_cos_1, w_sin_1, w_cos_2, w_sin_2  out  NUM_CH x W_W each  active weights.
- dirty  out  NUM_CH  per-channel shadow-modified flags.
- busy  out  1  state != IDLE.
- tick_err  out  1  sticky flag: a commit was forced by timeout.

Behaviour:
- Reset (RESET=1 at posedge CLOCK):
  - Active and shadow banks are 0; dirty=0.
  - State=IDLE; tick counter=0.
  - commit_ack=0; tick_err=0.
  - wr_ready is forced 0 while RESET is high.
  - A reset in mid-commit abandons the commit, with no partial apply.
- States are IDLE, ARMED and APPLY. All outputs are registered except wr_ready and busy, which decode directly from state.
- IDLE:
  - wr_ready=1.
  - On an accepted write: shadow[wr_chan] takes the four terms and dirty[wr_chan] is set. A repeat write to the same channel overwrites it.
  - commit_req with a dirty mask of 0 (after including any same-cycle write): commit_ack pulses on the next cycle and state stays IDLE (no-op commit).
  - commit_req with a nonzero mask moves to ARMED. A write accepted in the same cycle as commit_req is part of that commit.
- ARMED:
  - wr_ready=0.
  - The tick counter increments every cycle.
  - frame_tick=1 moves to APPLY.
  - If the counter reaches TICK_TIMEOUT-1 with no tick, move to APPLY and set tick_err.
  - commit_req is ignored.
- APPLY (exactly one cycle):
  - wr_ready=0.
  - At the closing edge, active[ch] takes shadow[ch] for every ch with dirty[ch]=1. Other channels keep their values.
  - At the same edge: dirty=0, commit_ack=1 for one cycle, counter=0, state goes to IDLE.
- Latency: frame_tick sampled in ARMED at cycle t gives APPLY at t+1; the new weights and commit_ack=1 are visible at t+2.
- frame_tick arriving in IDLE or APPLY is ignored.
- wr_chan >= NUM_CH: the write is accepted and discarded, with no dirty change.
- tick_err clears only on err_clr=1 or RESET. If err_clr is asserted in the same cycle as a timeout, the timeout wins and tick_err becomes 1.
- No arithmetic is performed; weights pass through unchanged at W_W bits.

Decomposition:
- Package bf_pkg holds:
  - Constants NUM_CH and W_W.
  - Typedef bf_wt_t, a packed struct {cos1, sin1, cos2, sin2}, each W_W bits.
  - Enum bf_commit_state_t {IDLE, ARMED, APPLY}.
- One sub-module, bf_tick_timer:
  - Inputs: enable and clear.
  - Output: a timeout pulse at TICK_TIMEOUT-1.
- The bank registers and FSM stay in the top of this block.

Test Plan:
- Reset, write ch3 {cos1=5'd7, sin1=5'd1, cos2=5'd31, sin2=5'd0}, commit, tick 3 cycles later -> w_cos_1[3]=7 and commit_ack=1 exactly 2 cycles after the tick; other channels 0; dirty=0.
- Write ch0=1 then ch0=2, commit, tick -> active ch0=2 only; never 1.
- commit_req with dirty=0 -> commit_ack at the next cycle; busy never rises; outputs unchanged.
- Write ch5 and commit, no frame_tick -> forced apply after 16 ARMED cycles; tick_err=1 and it stays 1 until err_clr.
- wr_valid held during ARMED -> wr_ready=0, shadow unchanged; write accepted on the first IDLE cycle after commit_ack.
- RESET asserted in ARMED with ch2 dirty -> all active=0, dirty=0, no commit_ack; a later frame_tick has no effect.
